// File: rtl/shift_pkg.sv
// Shared definitions for the execute-stage shift unit and its arbiter.
package shift_pkg;

  localparam int unsigned SHAMT_W = 5;

  typedef enum logic [1:0] {
    SHIFT_SLL = 2'b00,
    SHIFT_RSV = 2'b01,
    SHIFT_SRL = 2'b10,
    SHIFT_SRA = 2'b11
  } shift_op_e;

  localparam logic PORT_EXE = 1'b0;
  localparam logic PORT_MDU = 1'b1;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/shift_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the port favoured on a tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] valid_i,
  input  logic       advance_i,
  output logic [1:0] grant_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    grant_o = valid_i;
    if (valid_i == 2'b11) begin
      grant_o = ptr_q ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    // Favour the other port once the granted one has been served.
    if (advance_i) begin
      ptr_d = grant_o[0];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/shifter.sv
// Team combinational barrel shifter; the reserved op yields zero.
module shifter
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0]   a_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic [1:0]         op_i,
  output logic [WIDTH-1:0]   y_o
);

  always_comb begin
    y_o = '0;
    case (shift_op_e'(op_i))
      SHIFT_SLL: y_o = a_i << shamt_i;
      SHIFT_SRL: y_o = a_i >> shamt_i;
      SHIFT_SRA: y_o = $unsigned($signed(a_i) >>> shamt_i);
      default:   y_o = '0;
    endcase
  end

endmodule

// File: rtl/shift_arbiter.sv
// Shares one shifter between the execute stage and the mul/div helper,
// registering each result into a single id-tagged output slot.
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_A,
  input  logic [DATA_WIDTH-1:0] req0_B,
  input  logic [1:0]            req0_op,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_A,
  input  logic [DATA_WIDTH-1:0] req1_B,
  input  logic [1:0]            req1_op,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_id,
  output logic [CNT_WIDTH-1:0]  grant_cnt0,
  output logic [CNT_WIDTH-1:0]  grant_cnt1
);

  slot_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  id_q, id_d;
  logic [CNT_WIDTH-1:0]  cnt0_q, cnt0_d;
  logic [CNT_WIDTH-1:0]  cnt1_q, cnt1_d;

  logic [1:0]            grant;
  logic                  can_accept;
  logic                  accept0, accept1, accept;
  logic                  sel;
  logic [DATA_WIDTH-1:0] sh_a, sh_y;
  logic [SHAMT_W-1:0]    sh_amt;
  logic [1:0]            sh_op;

  logic unused_b_hi;
  assign unused_b_hi = ^{req0_B[DATA_WIDTH-1:SHAMT_W], req1_B[DATA_WIDTH-1:SHAMT_W]};

  rr_arb2 u_arb (
    .clk       (clk),
    .resetn    (resetn),
    .valid_i   ({req1_valid, req0_valid}),
    .advance_i (accept),
    .grant_o   (grant)
  );

  assign can_accept = (state_q == SLOT_EMPTY) || resp_ready;
  assign req0_ready = resetn && can_accept && grant[0];
  assign req1_ready = resetn && can_accept && grant[1];
  assign accept0    = req0_valid && req0_ready;
  assign accept1    = req1_valid && req1_ready;
  assign accept     = accept0 || accept1;

  assign sel    = grant[1] ? PORT_MDU : PORT_EXE;
  assign sh_a   = sel ? req1_A : req0_A;
  assign sh_amt = sel ? req1_B[SHAMT_W-1:0] : req0_B[SHAMT_W-1:0];
  assign sh_op  = sel ? req1_op : req0_op;

  shifter #(.WIDTH(DATA_WIDTH)) u_shifter (
    .a_i     (sh_a),
    .shamt_i (sh_amt),
    .op_i    (sh_op),
    .y_o     (sh_y)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    id_d    = id_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    case (state_q)
      SLOT_EMPTY: begin
        if (accept) state_d = SLOT_FULL;
      end
      SLOT_FULL: begin
        if (!accept && resp_ready) state_d = SLOT_EMPTY;
      end
      default: state_d = SLOT_EMPTY;
    endcase
    if (accept) begin
      data_d = sh_y;
      id_d   = sel;
    end
    if (accept0) cnt0_d = cnt0_q + 1'b1;
    if (accept1) cnt1_d = cnt1_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
      id_q    <= 1'b0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      id_q    <= id_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  assign resp_valid = (state_q == SLOT_FULL);
  assign resp_data  = data_q;
  assign resp_id    = id_q;
  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter with 2-bit grant counters to reach wrap.
module tb_shift_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 2;

  logic          clk = 1'b0;
  logic          resetn;
  logic          req0_valid, req0_ready;
  logic [DW-1:0] req0_A, req0_B;
  logic [1:0]    req0_op;
  logic          req1_valid, req1_ready;
  logic [DW-1:0] req1_A, req1_B;
  logic [1:0]    req1_op;
  logic          resp_valid, resp_ready;
  logic [DW-1:0] resp_data;
  logic          resp_id;
  logic [CW-1:0] grant_cnt0, grant_cnt1;

  int checks = 0;
  int errors = 0;

  shift_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_A     (req0_A),
    .req0_B     (req0_B),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_A     (req1_A),
    .req1_B     (req1_B),
    .req1_op    (req1_op),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    resetn = 1'b0; resp_ready = 1'b0;
    req0_valid = 1'b1; req0_A = '0; req0_B = '0; req0_op = 2'b00;
    req1_valid = 1'b0; req1_A = '0; req1_B = '0; req1_op = 2'b00;

    // Reset held for two cycles; ready must stay low even with a valid.
    #1;
    chk("rst_ready0_async", 32'(req0_ready), 32'd0);
    tick();
    tick();
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_cnt0", 32'(grant_cnt0), 32'd0);
    chk("rst_cnt1", 32'(grant_cnt1), 32'd0);
    chk("rst_ready0", 32'(req0_ready), 32'd0);
    chk("rst_ready1", 32'(req1_ready), 32'd0);

    req0_valid = 1'b0; resetn = 1'b1;
    tick();
    chk("idle_ready0", 32'(req0_ready), 32'd0);
    chk("idle_ready1", 32'(req1_ready), 32'd0);
    chk("idle_resp_valid", 32'(resp_valid), 32'd0);

    // Single SRA op on port 0.
    req0_A = 32'h8000_0001; req0_B = 32'd4; req0_op = 2'b11;
    req0_valid = 1'b1; resp_ready = 1'b1;
    #1;
    chk("single_ready0", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0;
    chk("single_valid", 32'(resp_valid), 32'd1);
    chk("single_data", resp_data, 32'hF800_0000);
    chk("single_id", 32'(resp_id), 32'd0);
    chk("single_cnt0", 32'(grant_cnt0), 32'd1);

    // Contention from a fresh pointer: grants alternate 0,1,0,1.
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    req1_A = 32'h1; req1_B = 32'h23; req1_op = 2'b00;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("cont_ready0", 32'(req0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("cont_ready1", 32'(req1_ready), (i % 2 == 1) ? 32'd1 : 32'd0);
      tick();
      chk("cont_valid", 32'(resp_valid), 32'd1);
      chk("cont_id", 32'(resp_id), 32'(i % 2));
      chk("cont_data", resp_data, (i % 2 == 1) ? 32'h8 : 32'hF800_0000);
    end
    chk("cont_cnt0", 32'(grant_cnt0), 32'd2);
    chk("cont_cnt1", 32'(grant_cnt1), 32'd2);

    // Backpressure: slot holds port-1 result 8, pointer favours port 0.
    resp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_ready0", 32'(req0_ready), 32'd0);
      chk("bp_ready1", 32'(req1_ready), 32'd0);
      tick();
      chk("bp_valid", 32'(resp_valid), 32'd1);
      chk("bp_data", resp_data, 32'h8);
      chk("bp_id", 32'(resp_id), 32'd1);
    end
    resp_ready = 1'b1;
    #1;
    chk("drain_ready0", 32'(req0_ready), 32'd1);
    chk("drain_ready1", 32'(req1_ready), 32'd0);
    tick();
    chk("drain_id", 32'(resp_id), 32'd0);
    chk("drain_data", resp_data, 32'hF800_0000);
    chk("drain_cnt0", 32'(grant_cnt0), 32'd3);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    chk("drain_empty", 32'(resp_valid), 32'd0);

    // Reserved op and counter wrap: five port-1 accepts on 2-bit counters.
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    req1_A = 32'hFFFF_FFFF; req1_B = 32'd7; req1_op = 2'b01; req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("rsv_ready1", 32'(req1_ready), 32'd1);
      tick();
      chk("rsv_data", resp_data, 32'd0);
      chk("rsv_id", 32'(resp_id), 32'd1);
    end
    chk("wrap_cnt1", 32'(grant_cnt1), 32'd1);
    chk("wrap_cnt0", 32'(grant_cnt0), 32'd0);
    req1_valid = 1'b0;

    // Port 0 accept moves the pointer to port 1, then reset mid-op.
    req0_A = 32'h1; req0_B = 32'd1; req0_op = 2'b00; req0_valid = 1'b1;
    tick();
    chk("pre_rst_data", resp_data, 32'h2);
    chk("pre_rst_id", 32'(resp_id), 32'd0);
    req0_valid = 1'b0;
    resetn = 1'b0;
    tick();
    chk("midrst_valid", 32'(resp_valid), 32'd0);
    chk("midrst_data", resp_data, 32'd0);
    chk("midrst_cnt1", 32'(grant_cnt1), 32'd0);
    resetn = 1'b1;
    req1_op = 2'b10; req1_A = 32'h80; req1_B = 32'd4;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("post_rst_ready0", 32'(req0_ready), 32'd1);
    chk("post_rst_ready1", 32'(req1_ready), 32'd0);
    tick();
    chk("post_rst_id", 32'(resp_id), 32'd0);
    chk("post_rst_data", resp_data, 32'h2);
    req0_valid = 1'b0;
    #1;
    chk("post_rst_next1", 32'(req1_ready), 32'd1);
    tick();
    chk("post_rst_srl", resp_data, 32'h8);
    chk("post_rst_id1", 32'(resp_id), 32'd1);
    req1_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares one combinational shift unit between two requesters: port 0 is the pipeline execute stage and port 1 is the multi-cycle mul/div helper.
- Uses round-robin arbitration with valid/ready handshakes on every channel.
- Registers each shift result into a single output slot tagged with the requester id.
- Sits beside the ALU in the execute stage. It keeps per-port grant counters for performance monitoring.

Parameters:
- DATA_WIDTH, 32: operand and result width.
- CNT_WIDTH, 16: width of each per-port grant counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- resetn  input  1  reset; synchronous and active-low.
- req0_valid  input  1  port 0 request valid.
- req0_ready  output  1  port 0 request accepted this cycle.
- req0_A  input  DATA_WIDTH  port 0 shift operand.
- req0_B  input  DATA_WIDTH  port 0 shift amount; only bits [4:0] are used.
- req0_op  input  2  port 0 shift op.
- req1_valid, req1_ready, req1_A, req1_B, req1_op: same as port 0, for port 1.
- resp_valid  output  1  result slot full.
- resp_ready  input  1  consumer takes the result.
- resp_data  output  DATA_WIDTH  shift result.
- resp_id  output  1  id of the port that issued the result.
- grant_cnt0  output  CNT_WIDTH  number of port 0 accepts.
- grant_cnt1  output  CNT_WIDTH  number of port 1 accepts.

Behaviour:
- Reset: resetn sampled low on a clk edge clears the following.
  - resp_valid=0, resp_data=0, resp_id=0.
  - Priority pointer = 0, so port 0 is favoured first.
  - grant_cnt0 = grant_cnt1 = 0.
  - A result held in the slot is discarded with no response.
  - reqX_ready = 0 while resetn is low.
- Shift ops (B[4:0] is the amount; B[31:5] is ignored):
  - 2'b00: logical left.
  - 2'b10: logical right.
  - 2'b11: arithmetic right.
  - 2'b01: reserved; result is 0, and the handshake still completes.
- Slot state machine:
  - EMPTY means resp_valid=0; FULL means resp_valid=1.
  - can_accept = EMPTY, or (FULL and resp_ready), i.e. drain and refill in the same cycle. Full throughput is 1 op/cycle.
- Arbitration (combinational, each cycle):
  - Only one valid: grant that port.
  - Both valid: grant the port the pointer names.
  - reqX_ready = can_accept AND grantX.
  - At most one ready is high per cycle.
  - ready may depend on valid. A requester must not make valid depend on ready.
- On an accept (reqX_valid and reqX_ready) at edge N:
  - From N+1, resp_data = shift(reqX_A, reqX_B, reqX_op), resp_id = X, resp_valid = 1.
  - Pointer becomes 1-X.
  - grant_cntX increments and wraps modulo 2^CNT_WIDTH.
- Pointer is unchanged on cycles with no accept.
- Outputs stay stable while FULL and not resp_ready: resp_data, resp_id and resp_valid hold.
- FULL and resp_ready with no accept: the slot goes EMPTY next cycle.
- Requesters must hold A, B and op stable while valid is high and not yet accepted. The block does not check this.
- Latency is 1 cycle from accept to resp_valid. There is no combinational path from req to resp.

Decomposition:
- Shared package (shift_pkg) holds:
  - Op encodings SHIFT_SLL=2'b00, SHIFT_SRL=2'b10, SHIFT_SRA=2'b11.
  - SHAMT_W=5.
  - Port id constants PORT_EXE=0, PORT_MDU=1.
- The shift datapath instantiates the team's existing shifter module. The block does not re-implement it.
- One natural sub-module, rr_arb2: 2-way round-robin arbiter holding the pointer. Inputs: valid[1:0], advance. Output: grant[1:0].

Test Plan:
- Reset then idle: resetn=0 for 2 cycles → resp_valid=0, counters 0, both ready=0 during reset; after release with no valids, ready stays 0.
- Single op: port 0 sends A=32'h8000_0001, B=4, op=SRA, with resp_ready=1 → accepted same cycle; next cycle resp_data=32'hF800_0000, resp_id=0, grant_cnt0=1.
- Contention: both valid every cycle with resp_ready=1 → accepts alternate 0,1,0,1 and one result per cycle. Port 1 uses A=32'h1, B=32'h23 (amount 3), op=SLL → result 32'h8. After 4 cycles both counters = 2.
- Backpressure: resp_ready=0 with the slot full → both ready=0 and resp_data/resp_id held for 5 cycles; raising resp_ready drains and accepts a new request in the same cycle.
- Reserved op and wrap: op=2'b01 with A=32'hFFFF_FFFF → resp_data=0. CNT_WIDTH=2 with 5 port-1 accepts → grant_cnt1=1.
- Reset mid-op: slot full, resetn=0 for one cycle → resp_valid=0 next cycle, pointer back to port 0. Both valid then → port 0 is granted first.
